// File: rtl/multiplier_shiftadd_param.sv
// multiplier_shiftadd_param: sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one multiplier bit per clock.
// Optional feature: define MULT_SIGNED_EN for two's-complement operands and result.
// Ports:
//   i_clk     clock, all state updates on posedge
//   i_rst_n   synchronous reset, active-low
//   i_st      start request, accepted in IDLE or DONE
//   i_mplier  multiplier, captured on the accepted start edge
//   i_mcand   multiplicand, captured on the accepted start edge
//   o_busy    high while the product is being computed
//   o_done    one-cycle pulse after o_result is updated
//   o_result  last completed product, held until the next one completes
module multiplier_shiftadd_param #(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_st,
    input  logic [WIDTH-1:0]   i_mplier,
    input  logic [WIDTH-1:0]   i_mcand,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_result
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             r_state, w_state_next;
    logic [2*WIDTH:0]   r_p, w_p_next;
    logic [WIDTH-1:0]   r_mc;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_result;
    logic [WIDTH:0]     w_hi, w_sum;
    logic               w_fill, w_last, w_load;

    if (WIDTH < 2) begin : g_bad_width
        $error("multiplier_shiftadd_param: WIDTH must be >= 2");
    end

    always_comb begin
        w_hi   = r_p[2*WIDTH:WIDTH];
        w_last = r_cnt == LAST;
        w_load = i_st && (r_state == IDLE || r_state == DONE);
`ifdef MULT_SIGNED_EN
        // multiplier MSB carries weight -2^(WIDTH-1), so the last step subtracts
        w_sum  = !r_p[0] ? w_hi :
                 w_last  ? w_hi - {r_mc[WIDTH-1], r_mc} : w_hi + {r_mc[WIDTH-1], r_mc};
        w_fill = w_sum[WIDTH];
`else
        w_sum  = w_hi + (r_p[0] ? {1'b0, r_mc} : '0);
        w_fill = 1'b0;
`endif
        w_p_next     = {w_fill, w_sum, r_p[WIDTH-1:1]};
        w_state_next = r_state == CALC ? (w_last ? DONE : CALC) :
                       w_load          ? CALC : IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_p      <= '0;
            r_mc     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_load) begin
            r_p   <= {{(WIDTH+1){1'b0}}, i_mplier};
            r_mc  <= i_mcand;
            r_cnt <= '0;
        end else if (r_state == CALC) begin
            r_p   <= w_p_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_result <= w_p_next[2*WIDTH-1:0];
        end
    end

    assign o_busy   = r_state == CALC;
    assign o_done   = r_state == DONE;
    assign o_result = r_result;
endmodule

// File: tb/tb_multiplier_shiftadd_param.sv
// tb_multiplier_shiftadd_param: directed self-checking bench for multiplier_shiftadd_param at WIDTH=4.
module tb_multiplier_shiftadd_param;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           st = 1'b0;
    logic [W-1:0]   mplier = '0;
    logic [W-1:0]   mcand = '0;
    logic           busy, done;
    logic [2*W-1:0] result;
    int             n_checks = 0;
    int             n_fail = 0;
    int             c1, c2;

    always #5 clk = ~clk;

    multiplier_shiftadd_param #(.WIDTH(W)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_st(st),
        .i_mplier(mplier),
        .i_mcand(mcand),
        .o_busy(busy),
        .o_done(done),
        .o_result(result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            cyc++;
            if (done) break;
        end
    endtask

    task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp);
        mplier = a;
        mcand  = b;
        st     = 1'b1;
        tick;
        st     = 1'b0;
        mplier = ~a;
        mcand  = ~b;
        check({tag, " busy@1"}, busy, 1);
        check({tag, " done@1"}, done, 0);
        for (int i = 2; i <= W; i++) begin
            tick;
            check({tag, " busy mid"}, busy, 1);
            check({tag, " done mid"}, done, 0);
        end
        tick;
        check({tag, " done"}, done, 1);
        check({tag, " busy at done"}, busy, 0);
        check({tag, " result"}, result, exp);
        tick;
        check({tag, " done cleared"}, done, 0);
        check({tag, " idle"}, busy, 0);
        check({tag, " result held"}, result, exp);
    endtask

    initial begin
        tick;
        tick;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result", result, 0);
        rst_n = 1'b1;
        tick;
        check("idle no start", busy, 0);

`ifdef MULT_SIGNED_EN
        run("s_m8x7", 4'h8, 4'h7, 8'hC8);
        run("s_m8xm8", 4'h8, 4'h8, 8'h40);
        run("s_m1xm1", 4'hF, 4'hF, 8'h01);
        run("s_5xm3", 4'h5, 4'hD, 8'hF1);
`else
        run("u_13x11", 4'd13, 4'd11, 8'h8F);
        run("u_15x15", 4'd15, 4'd15, 8'd225);
        run("u_0x9", 4'd0, 4'd9, 8'd0);
        run("u_9x0", 4'd9, 4'd0, 8'd0);
`endif

        mplier = 4'd3;
        mcand  = 4'd5;
        st     = 1'b1;
        tick;
        mplier = 4'd7;
        mcand  = 4'd6;
        wait_done(c1);
        check("b2b first latency", c1, W);
        check("b2b first result", result, 15);
        tick;
        check("b2b reload busy", busy, 1);
        check("b2b result held", result, 15);
        st = 1'b0;
        wait_done(c2);
        check("b2b done spacing", c2 + 1, W + 1);
        check("b2b second result", result, 42);
        tick;
        check("b2b back to idle", busy, 0);

        mplier = 4'd6;
        mcand  = 4'd5;
        st     = 1'b1;
        tick;
        st     = 1'b0;
        tick;
        st     = 1'b1;
        mplier = 4'd15;
        mcand  = 4'd15;
        tick;
        st     = 1'b0;
        wait_done(c1);
        check("st in calc latency", c1, W - 2);
        check("st in calc result", result, 30);
        tick;
        check("st in calc single done", done, 0);
        check("st in calc no restart", busy, 0);

        mplier = 4'd13;
        mcand  = 4'd11;
        st     = 1'b1;
        tick;
        st     = 1'b0;
        tick;
        rst_n  = 1'b0;
        tick;
        check("mid reset busy", busy, 0);
        check("mid reset done", done, 0);
        check("mid reset result", result, 0);
        rst_n = 1'b1;
        tick;
        check("post reset idle", busy, 0);
        run("after_reset_2x3", 4'd2, 4'd3, 8'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
